spart: RTL and testbench

SPART -- requirements
Module: spart

---
 rtl/spart.sv | 242 ++++++++++++++++++++++++
 tb/tb_spart.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spart.sv
// ---------------------------------------------------------------------------
// spart -- simple programmable asynchronous receiver/transmitter (8N1).
//
// A bus-side register file drives a transmitter and a receiver. Both are
// paced by a shared baud enable, and one bit time is 16 enables.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   iocs     in   chip select
//   iorw     in   1 = read (spart drives databus), 0 = write
//   ioaddr   in   00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//   databus  io   8-bit bidirectional bus, high-Z unless reading 00/01
//   rda      out  receive data available
//   tbr      out  transmit buffer ready (empty)
//   txd      out  serial out, idle high
//   rxd      in   serial in, idle high
//
// Optional feature: define SPART_LOOPBACK_EN to feed the receiver from the
// internal txd instead of rxd. The txd pin is still driven in that build.
// ---------------------------------------------------------------------------
module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // bus decode
  logic wr_sel, rd_sel, rd_buf, rd_stat;
  assign wr_sel  = iocs & ~iorw;
  assign rd_sel  = iocs & iorw;
  assign rd_buf  = rd_sel & (ioaddr == 2'b00);
  assign rd_stat = rd_sel & (ioaddr == 2'b01);

  // baud generator
  logic [15:0] div_q, baud_cnt_q;
  logic        baud_en;
  assign baud_en = (baud_cnt_q == '0);

  // A divisor write only changes the reload value; the running count
  // finishes first, so the new rate starts at the next reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= 16'd2604;
      baud_cnt_q <= 16'd2603;
    end else begin
      if (wr_sel && ioaddr == 2'b10) div_q[7:0]  <= databus;
      if (wr_sel && ioaddr == 2'b11) div_q[15:8] <= databus;
      if (baud_en) baud_cnt_q <= (div_q == '0) ? '0 : div_q - 16'd1;
      else         baud_cnt_q <= baud_cnt_q - 16'd1;
    end
  end

  // transmitter
  state_e     tx_state_q;
  logic       tbr_q, txd_q;
  logic [7:0] tx_buf_q, tx_sh_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;

  // tbr_q doubles as the tx_buf empty flag. A bus write needs tbr_q=1 and
  // the FSM only consumes the buffer when tbr_q=0, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
      tx_buf_q   <= '0;
      tx_sh_q    <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
    end else begin
      if (wr_sel && ioaddr == 2'b00 && tbr_q) begin
        tx_buf_q <= databus;
        tbr_q    <= 1'b0;
      end
      case (tx_state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (!tbr_q) begin
            tx_sh_q    <= tx_buf_q;
            tbr_q      <= 1'b1;
            tx_tick_q  <= '0;
            txd_q      <= 1'b0;
            tx_state_q <= ST_START;
          end
        end
        ST_START: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            txd_q      <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q   <= '0;
            tx_state_q <= ST_DATA;
          end
        end
        ST_DATA: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= ST_STOP;
            end else begin
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end
        end
        ST_STOP: if (baud_en) begin
          tx_tick_q <= tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            // a byte held in tx_buf starts straight away, no idle bit
            if (!tbr_q) begin
              tx_sh_q    <= tx_buf_q;
              tbr_q      <= 1'b1;
              txd_q      <= 1'b0;
              tx_state_q <= ST_START;
            end else begin
              tx_state_q <= ST_IDLE;
            end
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  // receiver input select
  logic rx_src;
`ifdef SPART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_src     = txd_q;
`else
  assign rx_src = rxd;
`endif

  state_e     rx_state_q;
  logic       rx_meta_q, rx_sync_q;
  logic [7:0] rx_sh_q, rx_buf_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic       rda_q, ovr_q, fe_q;
  logic       rda_d, ovr_d, fe_d;
  logic       stop_smp, byte_done, frame_err;

  assign stop_smp  = (rx_state_q == ST_STOP) && baud_en && (rx_tick_q == 4'd15);
  assign byte_done = stop_smp & rx_sync_q;
  assign frame_err = stop_smp & ~rx_sync_q;

  // A register read clears its flags, but an event on the same edge wins.
  always_comb begin
    rda_d = rda_q;
    ovr_d = ovr_q;
    fe_d  = fe_q;
    if (rd_buf)  rda_d = 1'b0;
    if (rd_stat) begin
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (byte_done) begin
      rda_d = 1'b1;
      if (rda_q) ovr_d = 1'b1;
    end
    if (frame_err) fe_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rda_q      <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
      rda_q     <= rda_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
      case (rx_state_q)
        ST_IDLE: if (!rx_sync_q) begin
          rx_tick_q  <= '0;
          rx_state_q <= ST_START;
        end
        // recheck the line at mid start bit to reject glitches
        ST_START: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
          end
        end
        ST_STOP: if (baud_en) begin
          rx_tick_q <= rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            if (rx_sync_q) rx_buf_q <= rx_sh_q;
            rx_state_q <= ST_IDLE;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  // bus read mux
  logic [7:0] rd_data;
  always_comb begin
    rd_data = rx_buf_q;
    if (ioaddr[0]) rd_data = {4'b0000, fe_q, ovr_q, tbr_q, rda_q};
  end
  assign databus = (rd_sel && !ioaddr[1]) ? rd_data : 'z;

  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_spart.sv
// ---------------------------------------------------------------------------
// tb_spart -- directed self-checking bench for spart.
// ---------------------------------------------------------------------------
module tb_spart;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] tb_dout;
  logic       tb_drv;
  logic       rxd;
  wire        rda, tbr, txd;

  int n_checks = 0;
  int n_fail   = 0;

  assign databus = tb_drv ? tb_dout : 'z;

  always #5 clk = ~clk;

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dout = d; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // Waits for a start bit, then samples n bits at mid-bit (64 clk per bit).
  task automatic expect_tx(input string tag, input logic [19:0] bits, input int n);
    int k;
    k = 0;
    while (txd !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k == 2000) check({tag, "_start_timeout"}, 16'(txd), 16'h0);
    clks(32);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 16'(txd), 16'(bits[i]));
      clks(64);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    clks(64);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(64);
    end
    rxd = stop;
    clks(64);
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int k, en_cnt;

    rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    tb_drv = 1'b0; tb_dout = 8'h00; rxd = 1'b1;
    clks(3);
    check("rst_txd", 16'(txd), 16'h1);
    check("rst_tbr", 16'(tbr), 16'h1);
    check("rst_rda", 16'(rda), 16'h0);
    bus_read(2'b01, d);
    check("rst_status", 16'(d), 16'h02);
    bus_read(2'b00, d);
    check("rst_rxbuf", 16'(d), 16'h00);
    rst = 1'b1;
    clks(2);

    // high-Z when not selected and for divisor reads
    check("idle_z", 16'(databus === 8'hzz), 16'h1);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
    #1 check("rd10_z", 16'(databus === 8'hzz), 16'h1);
    ioaddr = 2'b11;
    #1 check("rd11_z", 16'(databus === 8'hzz), 16'h1);
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;

    // divisor 1: enable every clk once the reset count has run out
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    bus_read(2'b01, d);
    check("div1_status", 16'(d), 16'h02);
    k = 0;
    while (dut.baud_en !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k == 3000) check("baud_en_timeout", 16'(dut.baud_en), 16'h1);
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en_cnt += int'(dut.baud_en);
    end
    check("div1_en_count", 16'(en_cnt), 16'd16);

    // divisor 4: 64 clk per bit
    bus_write(2'b10, 8'h04);
    clks(8);

    // single TX byte
    bus_write(2'b00, 8'hA5);
    check("tx_tbr_low", 16'(tbr), 16'h0);
    @(negedge clk);
    check("tx_tbr_back", 16'(tbr), 16'h1);
    expect_tx("txA5", {10'b0, 1'b1, 8'hA5, 1'b0}, 10);
    clks(64);

    // second byte accepted during START goes out right after the stop bit
    bus_write(2'b00, 8'hF0);
    bus_write(2'b00, 8'h0F);
    check("b2b_tbr_held", 16'(tbr), 16'h0);
    expect_tx("b2b", {1'b1, 8'h0F, 1'b0, 1'b1, 8'hF0, 1'b0}, 20);
    clks(64);
    check("b2b_tbr_end", 16'(tbr), 16'h1);
    check("b2b_txd_idle", 16'(txd), 16'h1);

`ifndef SPART_LOOPBACK_EN
    // single RX byte
    send_frame(8'h3C, 1'b1);
    check("rx3C_rda", 16'(rda), 16'h1);
    bus_read(2'b00, d);
    check("rx3C_data", 16'(d), 16'h3C);
    check("rx3C_rda_clr", 16'(rda), 16'h0);

    // overrun: status bit 1 (tbr) is checked on its own
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_read(2'b01, d);
    check("ovr_status", 16'(d & 8'hFD), 16'h05);
    check("ovr_tbr", 16'(d[1]), 16'h1);
    bus_read(2'b01, d);
    check("ovr_reread", 16'(d & 8'hFD), 16'h01);
    bus_read(2'b00, d);
    check("ovr_data", 16'(d), 16'h22);
    check("ovr_rda_clr", 16'(rda), 16'h0);

    // short low pulse is rejected at mid start bit
    rxd = 1'b0;
    clks(20);
    rxd = 1'b1;
    clks(700);
    check("glitch_rda", 16'(rda), 16'h0);
    bus_read(2'b01, d);
    check("glitch_status", 16'(d), 16'h02);

    // bad stop bit
    send_frame(8'h55, 1'b0);
    check("fe_rda", 16'(rda), 16'h0);
    bus_read(2'b01, d);
    check("fe_status", 16'(d), 16'h0A);
    clks(800);
`else
    // loopback: receiver follows internal txd, rxd ignored
    rxd = 1'b0;
    bus_write(2'b00, 8'h5A);
    clks(800);
    check("lb_rda", 16'(rda), 16'h1);
    bus_read(2'b00, d);
    check("lb_data", 16'(d), 16'h5A);
    rxd = 1'b1;
`endif

    // reset mid-frame forces the line idle at once
    bus_write(2'b00, 8'h00);
    clks(300);
    check("midrst_txd_pre", 16'(txd), 16'h0);
    rst = 1'b0;
    #1;
    check("midrst_txd", 16'(txd), 16'h1);
    check("midrst_tbr", 16'(tbr), 16'h1);
    check("midrst_rda", 16'(rda), 16'h0);
    clks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
